fft_frame_scheduler: RTL

// - Shares one xfft_v8_0 core between TX (IFFT of mapped OFDM symbols) and RX (FFT of received samples).
// - Per frame it arbitrates requesters, issues a config word carrying the FWD_INV bit, and streams NFFT samples with a regenerated tlast.
// - Core output frames are routed back to the requester that owns them, in order, via a tag FIFO.

---
 rtl/fft_frame_scheduler.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fft_frame_scheduler.sv
// ---------------------------------------------------------------------------
// fft_frame_scheduler
//
// Shares a single FFT core between a TX requester (inverse transforms) and
// an RX requester (forward transforms). Each frame is arbitrated, announced
// to the core with a config word carrying the direction bit, then streamed
// through with a locally regenerated tlast. A small tag FIFO remembers the
// direction of every frame in flight, so results coming back from the core
// are steered to the requester that owns them, in order.
//
// Optional feature macro: FFT_SCHED_STATS_EN (adds frame/error counters).
//
// Ports
//   aclk, areset                 clock, synchronous active-high reset
//   tx_s_* / rx_s_*              AXI-S frame inputs from TX / RX chains
//   core_cfg_*                   config word to the core
//   core_s_*                     sample stream to the core
//   core_m_*                     result stream from the core
//   tx_m_* / rx_m_*              result streams to TX / RX chains
//   frame_err                    pulse: source tlast disagreed with count
//   busy                         FSM not idle or frames still in flight
//   tx_frames, rx_frames,        (FFT_SCHED_STATS_EN only) output frame
//   err_count                    counters and saturating error counter
// ---------------------------------------------------------------------------
module fft_frame_scheduler #(
    parameter int          NFFT        = 64,
    parameter logic [23:0] CFG_BASE    = 24'h10_8404,
    parameter int          FWD_INV_BIT = 0,
    parameter int          TAG_DEPTH   = 4
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [31:0] tx_s_tdata,
    input  logic        tx_s_tvalid,
    input  logic        tx_s_tlast,
    output logic        tx_s_tready,
    input  logic [31:0] rx_s_tdata,
    input  logic        rx_s_tvalid,
    input  logic        rx_s_tlast,
    output logic        rx_s_tready,
    output logic [23:0] core_cfg_tdata,
    output logic        core_cfg_tvalid,
    input  logic        core_cfg_tready,
    output logic [31:0] core_s_tdata,
    output logic        core_s_tvalid,
    output logic        core_s_tlast,
    input  logic        core_s_tready,
    input  logic [31:0] core_m_tdata,
    input  logic        core_m_tvalid,
    input  logic        core_m_tlast,
    output logic        core_m_tready,
    output logic [31:0] tx_m_tdata,
    output logic        tx_m_tvalid,
    output logic        tx_m_tlast,
    input  logic        tx_m_tready,
    output logic [31:0] rx_m_tdata,
    output logic        rx_m_tvalid,
    output logic        rx_m_tlast,
    input  logic        rx_m_tready,
    output logic        frame_err,
    output logic        busy
`ifdef FFT_SCHED_STATS_EN
    ,
    output logic [15:0] tx_frames,
    output logic [15:0] rx_frames,
    output logic [7:0]  err_count
`endif
);

    localparam int CW = $clog2(NFFT);
    localparam int AW = $clog2(TAG_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_CFG, S_STREAM} state_t;

    // Direction encoding used for grant and tags: 0 = TX, 1 = RX.
    state_t          r_state;
    logic            r_grant;
    logic            r_rr;
    logic [CW-1:0]   r_count;
    logic            r_cfg_valid;
    logic            r_frame_err;

    logic            r_tag_mem [TAG_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_tag_cnt;

    logic            w_tag_empty;
    logic            w_tag_full;
    logic            w_head;
    logic            w_streaming;
    logic [31:0]     w_src_tdata;
    logic            w_src_tvalid;
    logic            w_src_tlast;
    logic            w_last_beat;
    logic            w_s_hs;
    logic            w_cfg_hs;
    logic            w_pop;

    assign w_tag_empty  = (r_tag_cnt == '0);
    assign w_tag_full   = (r_tag_cnt == (AW+1)'(TAG_DEPTH));
    assign w_head       = r_tag_mem[r_rd_ptr];
    assign w_streaming  = (r_state == S_STREAM);

    // Granted source selection; the source tlast is only used for checking.
    assign w_src_tdata  = r_grant ? rx_s_tdata  : tx_s_tdata;
    assign w_src_tvalid = r_grant ? rx_s_tvalid : tx_s_tvalid;
    assign w_src_tlast  = r_grant ? rx_s_tlast  : tx_s_tlast;
    assign w_last_beat  = (r_count == CW'(NFFT-1));

    assign core_s_tdata  = w_src_tdata;
    assign core_s_tvalid = w_streaming & w_src_tvalid;
    assign core_s_tlast  = w_streaming & w_last_beat;
    assign tx_s_tready   = w_streaming & ~r_grant & core_s_tready;
    assign rx_s_tready   = w_streaming &  r_grant & core_s_tready;

    assign w_s_hs   = core_s_tvalid & core_s_tready;
    assign w_cfg_hs = r_cfg_valid & core_cfg_tready;

    // Config word: base pattern with the direction bit substituted.
    generate
        for (genvar gi = 0; gi < 24; gi++) begin : g_cfg
            if (gi == FWD_INV_BIT) begin : g_dir
                assign core_cfg_tdata[gi] = r_grant;
            end else begin : g_base
                assign core_cfg_tdata[gi] = CFG_BASE[gi];
            end
        end
    endgenerate
    assign core_cfg_tvalid = r_cfg_valid;

    // Result routing is independent of the FSM. With no tag there is no
    // owner for the data, so the core is stalled rather than drained.
    assign tx_m_tdata    = core_m_tdata;
    assign rx_m_tdata    = core_m_tdata;
    assign tx_m_tlast    = core_m_tlast;
    assign rx_m_tlast    = core_m_tlast;
    assign tx_m_tvalid   = core_m_tvalid & ~w_tag_empty & ~w_head;
    assign rx_m_tvalid   = core_m_tvalid & ~w_tag_empty &  w_head;
    assign core_m_tready = ~w_tag_empty & (w_head ? rx_m_tready : tx_m_tready);
    assign w_pop         = core_m_tvalid & core_m_tready & core_m_tlast;

    assign frame_err = r_frame_err;
    assign busy      = (r_state != S_IDLE) | ~w_tag_empty;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= S_IDLE;
            r_grant     <= 1'b0;
            r_rr        <= 1'b0;
            r_count     <= '0;
            r_cfg_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_s_hs & (w_src_tlast != w_last_beat);
            case (r_state)
                S_IDLE: begin
                    if (!w_tag_full && (tx_s_tvalid || rx_s_tvalid)) begin
                        if (tx_s_tvalid && rx_s_tvalid) begin
                            r_grant <= r_rr;
                            r_rr    <= ~r_rr;
                        end else begin
                            r_grant <= rx_s_tvalid;
                        end
                        r_count     <= '0;
                        r_cfg_valid <= 1'b1;
                        r_state     <= S_CFG;
                    end
                end
                S_CFG: begin
                    if (w_cfg_hs) begin
                        r_cfg_valid <= 1'b0;
                        r_count     <= '0;
                        r_state     <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    // The count parks at NFFT-1; it is cleared on the next grant.
                    if (w_s_hs) begin
                        if (w_last_beat) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tag storage. A push only happens from CFG, which is entered only when
    // the FIFO has room, so no overflow guard is needed here.
    always_ff @(posedge aclk) begin
        if (w_cfg_hs) begin
            r_tag_mem[r_wr_ptr] <= r_grant;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_tag_cnt <= '0;
        end else begin
            if (w_cfg_hs) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_cfg_hs, w_pop})
                2'b10:   r_tag_cnt <= r_tag_cnt + 1'b1;
                2'b01:   r_tag_cnt <= r_tag_cnt - 1'b1;
                default: r_tag_cnt <= r_tag_cnt;
            endcase
        end
    end

`ifdef FFT_SCHED_STATS_EN
    logic [15:0] r_tx_frames;
    logic [15:0] r_rx_frames;
    logic [7:0]  r_err_count;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_tx_frames <= '0;
            r_rx_frames <= '0;
            r_err_count <= '0;
        end else begin
            if (tx_m_tvalid && tx_m_tready && core_m_tlast) begin
                r_tx_frames <= r_tx_frames + 1'b1;
            end
            if (rx_m_tvalid && rx_m_tready && core_m_tlast) begin
                r_rx_frames <= r_rx_frames + 1'b1;
            end
            if (r_frame_err && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    assign tx_frames = r_tx_frames;
    assign rx_frames = r_rx_frames;
    assign err_count = r_err_count;
`endif

endmodule
